// File: rtl/rsp_stream_ctrl_if.sv
// Handshake and scratchpad-control bundle for the stream sequencing controller.
// The slave side is the controller itself; the master side is the environment
// (producer, consumer and scratchpad address/enable consumer).
interface rsp_stream_ctrl_if #(
   parameter int ADDR_WIDTH = 3
);

   logic                  start;
   logic [ADDR_WIDTH:0]   stride;
   logic                  in_valid;
   logic                  in_last;
   logic                  in_ready;
   logic                  out_valid;
   logic                  out_ready;
   logic                  done;
   logic                  sp_wen;
   logic [ADDR_WIDTH-1:0] sp_waddr;
   logic [ADDR_WIDTH-1:0] sp_raddr;
   logic [ADDR_WIDTH:0]   count;

   modport master (
      output start, stride, in_valid, in_last, out_ready,
      input  in_ready, out_valid, done, sp_wen, sp_waddr, sp_raddr, count
   );

   modport slave (
      input  start, stride, in_valid, in_last, out_ready,
      output in_ready, out_valid, done, sp_wen, sp_waddr, sp_raddr, count
   );

endinterface

// File: rtl/rsp_stream_ctrl.sv
// Sequencing controller that runs a parallel-write / parallel-read scratchpad
// as a circular window buffer: producer beats of PAR_WRITE words go in at the
// write pointer, the consumer sees a PAR_READ-word window at the read pointer
// and retires a clamped stride of words per handshake.
module rsp_stream_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int PAR_WRITE  = 2,
   parameter int PAR_READ   = 1
) (
   input logic               clk_i,
   input logic               rst_ni,
   rsp_stream_ctrl_if.slave  bus
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   // Word counts are carried one bit wider than addresses so DEPTH itself fits.
   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   PW_W    = (ADDR_WIDTH+1)'(PAR_WRITE);
   localparam logic [ADDR_WIDTH:0]   PR_W    = (ADDR_WIDTH+1)'(PAR_READ);
   localparam logic [ADDR_WIDTH:0]   ONE_W   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PW_A    = ADDR_WIDTH'(PAR_WRITE);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      STREAM,
      DRAIN
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH:0]   stride_q, stride_d;

   logic                  inReady;
   logic                  outValid;
   logic                  push;
   logic                  pop;
   logic                  doneNow;
   logic [ADDR_WIDTH:0]   freeWords;
   logic [ADDR_WIDTH:0]   countNext;
   logic [ADDR_WIDTH:0]   strideClamped;

   // Handshakes and occupancy arithmetic; a pop never frees room for a same-cycle push.
   always_comb begin
      freeWords = DEPTH_W - count_q;
      inReady   = ((state_q == FILL) || (state_q == STREAM)) && (freeWords >= PW_W);
      outValid  = ((state_q == STREAM) || (state_q == DRAIN)) && (count_q >= PR_W);
      push      = bus.in_valid & inReady;
      pop       = outValid & bus.out_ready;
      countNext = count_q + (push ? PW_W : '0) - (pop ? stride_q : '0);
   end

   // Stride is forced into 1..PAR_READ so a pop never retires more than the window.
   always_comb begin
      strideClamped = bus.stride;
      if (bus.stride == '0) begin
         strideClamped = ONE_W;
      end else if (bus.stride > PR_W) begin
         strideClamped = PR_W;
      end
   end

   // Next-state logic for the frame sequencer plus pointer and count updates.
   always_comb begin
      state_d  = state_q;
      wrPtr_d  = push ? (wrPtr_q + PW_A) : wrPtr_q;
      rdPtr_d  = pop ? (rdPtr_q + stride_q[ADDR_WIDTH-1:0]) : rdPtr_q;
      count_d  = countNext;
      stride_d = stride_q;
      doneNow  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = FILL;
               wrPtr_d  = '0;
               rdPtr_d  = '0;
               count_d  = '0;
               stride_d = strideClamped;
            end
         end
         FILL: begin
            if (push && bus.in_last) begin
               state_d = DRAIN;
            end else if (countNext >= PR_W) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (push && bus.in_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!pop && (count_q < PR_W)) begin
               doneNow = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, pointer, occupancy and stride registers with asynchronous abort.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         count_q  <= '0;
         stride_q <= '0;
      end else begin
         state_q  <= state_d;
         wrPtr_q  <= wrPtr_d;
         rdPtr_q  <= rdPtr_d;
         count_q  <= count_d;
         stride_q <= stride_d;
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid;
   assign bus.done      = doneNow;
   assign bus.sp_wen    = push;
   assign bus.sp_waddr  = wrPtr_q;
   assign bus.sp_raddr  = rdPtr_q;
   assign bus.count     = count_q;

endmodule

// File: tb/tb_rsp_stream_ctrl.sv
// Directed bench for rsp_stream_ctrl: one instance with default parameters
// (DEPTH 8, PAR_WRITE 2, PAR_READ 1) and one with PAR_READ 3.
module tb_rsp_stream_ctrl;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   rsp_stream_ctrl_if #(.ADDR_WIDTH(3)) busA ();
   rsp_stream_ctrl_if #(.ADDR_WIDTH(3)) busB ();

   rsp_stream_ctrl #(.ADDR_WIDTH(3), .PAR_WRITE(2), .PAR_READ(1)) dutA (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (busA.slave)
   );

   rsp_stream_ctrl #(.ADDR_WIDTH(3), .PAR_WRITE(2), .PAR_READ(3)) dutB (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (busB.slave)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   task automatic idleInputs();
      busA.start = 1'b0; busA.stride = '0; busA.in_valid = 1'b0; busA.in_last = 1'b0; busA.out_ready = 1'b0;
      busB.start = 1'b0; busB.stride = '0; busB.in_valid = 1'b0; busB.in_last = 1'b0; busB.out_ready = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk);
      idleInputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic startA(input logic [3:0] s);
      busA.start = 1'b1;
      busA.stride = s;
      @(negedge clk);
      busA.start = 1'b0;
   endtask

   task automatic startB(input logic [3:0] s);
      busB.start = 1'b1;
      busB.stride = s;
      @(negedge clk);
      busB.start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      idleInputs();
      #2;
      rst_n = 1'b0;
      #2;
      checks++;
      if (busA.count !== 4'd0 || busB.count !== 4'd0) begin
         errors++; $display("[TB] FAIL reset_count: got A=%0d B=%0d expected 0", busA.count, busB.count);
      end
      checks++;
      if (busA.in_ready !== 1'b0 || busA.out_valid !== 1'b0 || busA.sp_wen !== 1'b0 || busA.done !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_flags: got rdy=%0b vld=%0b wen=%0b done=%0b expected all 0",
                            busA.in_ready, busA.out_valid, busA.sp_wen, busA.done);
      end
      checks++;
      if (busA.sp_waddr !== 3'd0 || busA.sp_raddr !== 3'd0) begin
         errors++; $display("[TB] FAIL reset_ptrs: got w=%0d r=%0d expected 0", busA.sp_waddr, busA.sp_raddr);
      end
   endtask

   task automatic test_basic();
      int nW = 0;
      int nR = 0;
      int nDone = 0;
      doReset();
      startA(4'd1);
      for (int cyc = 0; cyc < 20; cyc++) begin
         busA.in_valid = (nW < 4);
         busA.in_last = (nW == 3);
         busA.out_ready = 1'b1;
         #1;
         if (busA.in_valid && busA.in_ready) begin
            checks++;
            if (busA.sp_wen !== 1'b1 || busA.sp_waddr !== 3'(2*nW)) begin
               errors++; $display("[TB] FAIL basic_waddr: got wen=%0b addr=%0d expected wen=1 addr=%0d",
                                  busA.sp_wen, busA.sp_waddr, 2*nW);
            end
            nW++;
         end
         if (busA.out_valid && busA.out_ready) begin
            checks++;
            if (busA.sp_raddr !== 3'(nR)) begin
               errors++; $display("[TB] FAIL basic_raddr: got %0d expected %0d", busA.sp_raddr, nR);
            end
            nR++;
         end
         if (busA.done === 1'b1) begin
            nDone++;
            checks++;
            if (nR != 8) begin
               errors++; $display("[TB] FAIL basic_pops_at_done: got %0d expected 8", nR);
            end
         end
         @(negedge clk);
      end
      idleInputs();
      checks++;
      if (nW != 4 || nR != 8) begin
         errors++; $display("[TB] FAIL basic_totals: got beats=%0d pops=%0d expected 4 and 8", nW, nR);
      end
      checks++;
      if (nDone != 1) begin
         errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", nDone);
      end
      busA.in_valid = 1'b1;
      #1;
      checks++;
      if (busA.in_ready !== 1'b0 || busA.out_valid !== 1'b0 || busA.sp_wen !== 1'b0) begin
         errors++; $display("[TB] FAIL basic_idle: got rdy=%0b vld=%0b wen=%0b expected 0",
                            busA.in_ready, busA.out_valid, busA.sp_wen);
      end
      busA.in_valid = 1'b0;
   endtask

   task automatic test_full();
      doReset();
      startA(4'd1);
      busA.in_valid = 1'b1;
      busA.out_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         #1;
         checks++;
         if (busA.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL full_accept_beat%0d: got in_ready=%0b expected 1", b, busA.in_ready);
         end
         @(negedge clk);
      end
      for (int c = 0; c < 3; c++) begin
         busA.start = (c == 0);
         #1;
         checks++;
         if (busA.count !== 4'd8 || busA.in_ready !== 1'b0 || busA.sp_wen !== 1'b0) begin
            errors++; $display("[TB] FAIL full_hold: got count=%0d rdy=%0b wen=%0b expected 8 0 0",
                               busA.count, busA.in_ready, busA.sp_wen);
         end
         @(negedge clk);
      end
      busA.start = 1'b0;
      busA.out_ready = 1'b1;
      #1;
      checks++;
      if (busA.out_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL full_out_valid: got %0b expected 1", busA.out_valid);
      end
      @(negedge clk);
      busA.out_ready = 1'b0;
      #1;
      checks++;
      if (busA.count !== 4'd7 || busA.in_ready !== 1'b0 || busA.sp_wen !== 1'b0) begin
         errors++; $display("[TB] FAIL full_after_pop: got count=%0d rdy=%0b wen=%0b expected 7 0 0",
                            busA.count, busA.in_ready, busA.sp_wen);
      end
      busA.in_valid = 1'b0;
   endtask

   task automatic test_wrap();
      int nW = 0;
      int nR = 0;
      int nDone = 0;
      logic prevBoth = 1'b0;
      logic [3:0] prevCount = '0;
      doReset();
      startB(4'd2);
      for (int cyc = 0; cyc < 20; cyc++) begin
         busB.in_valid = (nW < 8);
         busB.in_last = (nW == 7);
         busB.out_ready = 1'b1;
         #1;
         if (prevBoth) begin
            checks++;
            if (busB.count !== prevCount) begin
               errors++; $display("[TB] FAIL wrap_net_zero: got %0d expected %0d", busB.count, prevCount);
            end
         end
         checks++;
         if (busB.out_valid === 1'b1 && busB.count < 4'd3) begin
            errors++; $display("[TB] FAIL wrap_valid_low_count: got out_valid=1 count=%0d expected out_valid=0", busB.count);
         end
         prevBoth = busB.in_valid && busB.in_ready && busB.out_valid;
         prevCount = busB.count;
         if (busB.in_valid && busB.in_ready) begin
            checks++;
            if (busB.sp_waddr !== 3'(2*nW)) begin
               errors++; $display("[TB] FAIL wrap_waddr: got %0d expected %0d", busB.sp_waddr, (2*nW) % 8);
            end
            nW++;
         end
         if (busB.out_valid && busB.out_ready) begin
            checks++;
            if (busB.sp_raddr !== 3'(2*nR)) begin
               errors++; $display("[TB] FAIL wrap_raddr: got %0d expected %0d", busB.sp_raddr, (2*nR) % 8);
            end
            nR++;
         end
         if (busB.done === 1'b1) begin
            nDone++;
            checks++;
            if (nR != 7 || busB.count !== 4'd2) begin
               errors++; $display("[TB] FAIL wrap_at_done: got pops=%0d count=%0d expected 7 and 2", nR, busB.count);
            end
         end
         @(negedge clk);
      end
      idleInputs();
      checks++;
      if (nDone != 1 || nW != 8) begin
         errors++; $display("[TB] FAIL wrap_totals: got done=%0d beats=%0d expected 1 and 8", nDone, nW);
      end
   endtask

   task automatic test_stride_clamp();
      logic [3:0] strideIn[2];
      logic [2:0] expAddr[2];
      logic [3:0] expCount[2];
      strideIn[0] = 4'd0; expAddr[0] = 3'd1; expCount[0] = 4'd3;
      strideIn[1] = 4'd5; expAddr[1] = 3'd3; expCount[1] = 4'd1;
      for (int t = 0; t < 2; t++) begin
         doReset();
         startB(strideIn[t]);
         busB.in_valid = 1'b1;
         repeat (2) @(negedge clk);
         busB.in_valid = 1'b0;
         busB.out_ready = 1'b1;
         #1;
         checks++;
         if (busB.out_valid !== 1'b1 || busB.sp_raddr !== 3'd0) begin
            errors++; $display("[TB] FAIL clamp_pre_pop%0d: got vld=%0b raddr=%0d expected 1 0", t, busB.out_valid, busB.sp_raddr);
         end
         @(negedge clk);
         busB.out_ready = 1'b0;
         #1;
         checks++;
         if (busB.sp_raddr !== expAddr[t] || busB.count !== expCount[t]) begin
            errors++; $display("[TB] FAIL clamp_step%0d: got raddr=%0d count=%0d expected %0d %0d",
                               t, busB.sp_raddr, busB.count, expAddr[t], expCount[t]);
         end
      end
   endtask

   task automatic test_drain();
      int nW = 0;
      int nR = 0;
      int nDone = 0;
      doReset();
      startB(4'd3);
      for (int cyc = 0; cyc < 12; cyc++) begin
         busB.in_valid = (nW < 4);
         busB.in_last = (nW == 3);
         busB.out_ready = 1'b1;
         #1;
         checks++;
         if (busB.out_valid === 1'b1 && busB.count < 4'd3) begin
            errors++; $display("[TB] FAIL drain_valid_low_count: got out_valid=1 count=%0d expected out_valid=0", busB.count);
         end
         if (busB.in_valid && busB.in_ready) nW++;
         if (busB.out_valid && busB.out_ready) begin
            checks++;
            if (busB.sp_raddr !== 3'(3*nR)) begin
               errors++; $display("[TB] FAIL drain_raddr: got %0d expected %0d", busB.sp_raddr, 3*nR);
            end
            nR++;
         end
         if (busB.done === 1'b1) begin
            nDone++;
            checks++;
            if (nR != 2 || busB.count !== 4'd2) begin
               errors++; $display("[TB] FAIL drain_at_done: got pops=%0d count=%0d expected 2 and 2", nR, busB.count);
            end
         end
         @(negedge clk);
      end
      idleInputs();
      checks++;
      if (nDone != 1 || nR != 2 || nW != 4) begin
         errors++; $display("[TB] FAIL drain_totals: got done=%0d pops=%0d beats=%0d expected 1 2 4", nDone, nR, nW);
      end
   endtask

   task automatic test_reset_mid();
      doReset();
      startA(4'd1);
      busA.in_valid = 1'b1;
      repeat (3) @(negedge clk);
      busA.in_valid = 1'b0;
      busA.out_ready = 1'b1;
      @(negedge clk);
      busA.out_ready = 1'b0;
      #1;
      checks++;
      if (busA.count !== 4'd5 || busA.in_ready !== 1'b1 || busA.out_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL midreset_setup: got count=%0d rdy=%0b vld=%0b expected 5 1 1",
                            busA.count, busA.in_ready, busA.out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busA.count !== 4'd0 || busA.in_ready !== 1'b0 || busA.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL midreset_abort: got count=%0d rdy=%0b vld=%0b expected 0 0 0",
                            busA.count, busA.in_ready, busA.out_valid);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 2) rst_n = 1'b1;
         #1;
         checks++;
         if (busA.done !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_no_done: got %0b expected 0", busA.done);
         end
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      clk = 1'b0;
      errors = 0;
      checks = 0;
      test_reset();
      test_basic();
      test_full();
      test_wrap();
      test_stride_clamp();
      test_drain();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rsp_stream_ctrl.md
Name: rsp_stream_ctrl

Overview:
- Sequencing controller for the parallel-write / parallel-read scratchpad. It drives the scratchpad as a circular window buffer.
- Producer side: accepts PAR_WRITE-word beats over a valid/ready handshake and generates the scratchpad write enable and write address.
- Consumer side: exposes a PAR_READ-word window at a read address, and advances that address by a programmable stride on each consumer handshake.
- Tracks occupancy, blocks overflow and underflow, and sequences one frame from start to done.

Parameters:
- ADDR_WIDTH, 3, scratchpad address width; DEPTH = 2**ADDR_WIDTH words.
- PAR_WRITE, 2, words written per accepted beat; DEPTH must be a multiple of PAR_WRITE.
- PAR_READ, 1, words in the read window; PAR_READ <= DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle frame start; honoured only in IDLE.
- stride  in  ADDR_WIDTH+1  words retired per window pop; sampled on start.
- in_valid  in  1  producer beat valid.
- in_last  in  1  marks the final producer beat of the frame; qualified by in_valid & in_ready.
- in_ready  out  1  controller can accept a beat this cycle.
- out_valid  out  1  a full PAR_READ window is readable at sp_raddr.
- out_ready  in  1  consumer retires the window this cycle.
- done  out  1  one-cycle pulse when the frame has fully drained.
- sp_wen  out  1  scratchpad write enable.
- sp_waddr  out  ADDR_WIDTH  scratchpad write address (write pointer).
- sp_raddr  out  ADDR_WIDTH  scratchpad read address (read pointer).
- count  out  ADDR_WIDTH+1  occupied words, 0..DEPTH.

Behaviour:
- Reset (rst low, async): state IDLE; wr_ptr, rd_ptr, count, stride_q, done all 0. in_ready, out_valid and sp_wen are 0.
- Addressing:
  - All pointers wrap modulo DEPTH.
  - The connected scratchpad indexes its PAR_WRITE / PAR_READ lanes modulo DEPTH.
  - sp_waddr = wr_ptr and sp_raddr = rd_ptr at all times.
- States: IDLE, FILL, STREAM, DRAIN.
  - IDLE: in_ready=0, out_valid=0. On start, go to FILL; clear wr_ptr, rd_ptr and count; latch stride_q = clamp(stride, 1, PAR_READ), so 0 becomes 1 and values above PAR_READ become PAR_READ.
  - FILL: out_valid=0. Go to STREAM when next count >= PAR_READ. An accepted in_last goes to DRAIN regardless of count.
  - STREAM: push and pop both allowed. An accepted in_last goes to DRAIN.
  - DRAIN: in_ready=0. Pops continue while count >= PAR_READ. When count < PAR_READ and no pop is occurring this cycle: done=1 for one cycle, go to IDLE. Leftover words (< PAR_READ) are discarded.
- Write handshake:
  - in_ready = (state is FILL or STREAM) & (DEPTH - count >= PAR_WRITE).
  - A pop in the same cycle is not credited toward in_ready.
  - push = in_valid & in_ready; sp_wen = push (combinational, same cycle).
  - On push, wr_ptr += PAR_WRITE.
- Read handshake:
  - out_valid = (state is STREAM or DRAIN) & (count >= PAR_READ).
  - pop = out_valid & out_ready. On pop, rd_ptr += stride_q.
  - Window data is combinational at sp_raddr: zero-latency read.
- Occupancy: count_next = count + (push ? PAR_WRITE : 0) - (pop ? stride_q : 0). Simultaneous push and pop is legal, and count never leaves 0..DEPTH.
- Frame boundaries:
  - start outside IDLE is ignored.
  - The in_last beat itself is written.
  - in_valid while in_ready=0 has no effect.
  - Reset mid-frame aborts immediately to the reset values; no done pulse.

Test Plan:
- Defaults (DEPTH 8, PW 2, PR 1), start with stride=1, push 4 beats with in_last on the 4th, out_ready=1 from cycle 0. Required: sp_waddr sequence 0,2,4,6; exactly 8 pops with sp_raddr 0..7; done pulses once after the 8th pop; state returns to IDLE.
- Full: defaults, out_ready=0, push continuously. Required: in_ready drops after 4 beats at count=8; sp_wen stays 0 while in_valid stays 1. One pop then gives count=7; in_ready remains 0 (free=1 < 2).
- Wrap and simultaneous events (PR=3, stride=2): long stream with out_ready=1. Required: wr_ptr wraps 6→0; sp_raddr walks 0,2,4,6,0; each cycle with push and pop gives net count change +0.
- Stride clamp (PR=3): start with stride=0, then stride=5. Required: rd_ptr steps 1, then 3.
- Drain leftovers (PR=3, stride=3): push 4 beats (8 words) with in_last. Required: exactly 2 pops (raddr 0,3); count=2; done then pulses; out_valid never asserts with count<3.
- Reset mid-STREAM: assert rst low asynchronously with count=5. Required: count=0, in_ready=0 and out_valid=0 immediately; done never pulses.
